// File: rtl/dual_issue_scheduler_pkg.sv
// dual_issue_scheduler_pkg
//   Shared decode definitions for the dual-issue scheduler: instruction field
//   positions, opcode values, class / slot-need / state encodings, register
//   mask bits and small decode helpers.
//   Field layout: op[31:26] rs[25:21] rt[20:16] rd[15:11].
//   Opcodes: 00xxxx ALU-R, 01xxxx ALU-I, 10xxxx MEM, 11xxxx BR.
//   CMP/TEST/JR sit in the ALU-R space; CMPI/TESTI sit in the ALU-I space.
package dual_issue_scheduler_pkg;

  localparam int OP_LSB = 26;
  localparam int RS_LSB = 21;
  localparam int RT_LSB = 16;
  localparam int RD_LSB = 11;
  localparam int REG_W  = 5;
  localparam int BUSY_W = 3;  // holds LOAD_LATENCY up to 7

  localparam logic [5:0] OP_JR    = 6'b001101;
  localparam logic [5:0] OP_CMP   = 6'b001110;
  localparam logic [5:0] OP_TEST  = 6'b001111;
  localparam logic [5:0] OP_CMPI  = 6'b011110;
  localparam logic [5:0] OP_TESTI = 6'b011111;
  localparam logic [5:0] OP_LW    = 6'b100000;
  localparam logic [5:0] OP_SW    = 6'b100001;
  localparam logic [5:0] OP_LA    = 6'b100010;
  localparam logic [5:0] OP_SA    = 6'b100011;

  localparam logic [2:0] REG_MASK_RS = 3'b001;
  localparam logic [2:0] REG_MASK_RT = 3'b010;
  localparam logic [2:0] REG_MASK_RD = 3'b100;

  typedef enum logic [2:0] {CLS_NOP, CLS_ALU, CLS_FLAG, CLS_MEM, CLS_BR} cls_e;
  typedef enum logic [1:0] {NEED_ANY, NEED_S0, NEED_S1} need_e;
  typedef enum logic {S_PAIR, S_REPLAY} state_e;

  typedef struct packed {
    cls_e             cls;
    need_e            need;
    logic [2:0]       src;
    logic [2:0]       dst;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
  } dec_t;

  // Destination register number; only meaningful when dst != 0.
  function automatic logic [REG_W-1:0] dst_reg(dec_t d);
    return ((d.dst & REG_MASK_RD) != 3'b0) ? d.rd : d.rt;
  endfunction

  function automatic logic reads(dec_t d, logic [REG_W-1:0] r);
    return (((d.src & REG_MASK_RS) != 3'b0) && d.rs == r) ||
           (((d.src & REG_MASK_RT) != 3'b0) && d.rt == r) ||
           (((d.src & REG_MASK_RD) != 3'b0) && d.rd == r);
  endfunction

endpackage

// File: rtl/dual_issue_scheduler_inst_classifier.sv
// inst_classifier
//   Combinational decode of one instruction into class, pipe need, source and
//   destination register masks and register numbers.
//   Ports: inst_i (instruction), dec_o (decoded record).
module inst_classifier
  import dual_issue_scheduler_pkg::*;
#(
  parameter int INST_WIDTH = 32
) (
  input  logic [INST_WIDTH-1:0] inst_i,
  output dec_t                  dec_o
);

  logic [5:0] op;
  assign op = inst_i[OP_LSB +: 6];

  always_comb begin
    dec_o      = '0;
    dec_o.cls  = CLS_NOP;
    dec_o.need = NEED_ANY;
    dec_o.rs   = inst_i[RS_LSB +: REG_W];
    dec_o.rt   = inst_i[RT_LSB +: REG_W];
    dec_o.rd   = inst_i[RD_LSB +: REG_W];
    if (inst_i == '0) begin
      dec_o.cls = CLS_NOP;
    end else if (op == OP_JR) begin
      dec_o.cls  = CLS_BR;
      dec_o.need = NEED_S0;
      dec_o.src  = REG_MASK_RS;
    end else if (op == OP_CMP || op == OP_TEST) begin
      dec_o.cls  = CLS_FLAG;
      dec_o.need = NEED_S0;
      dec_o.src  = REG_MASK_RS | REG_MASK_RT;
    end else if (op == OP_CMPI || op == OP_TESTI) begin
      dec_o.cls  = CLS_FLAG;
      dec_o.need = NEED_S0;
      dec_o.src  = REG_MASK_RS;
    end else begin
      unique case (op[5:4])
        2'b00: begin
          dec_o.cls = CLS_ALU;
          dec_o.src = REG_MASK_RS | REG_MASK_RT;
          dec_o.dst = REG_MASK_RD;
        end
        2'b01: begin
          dec_o.cls = CLS_ALU;
          dec_o.src = REG_MASK_RS;
          dec_o.dst = REG_MASK_RT;
        end
        2'b10: begin
          dec_o.cls  = CLS_MEM;
          dec_o.need = NEED_S1;
          unique case (op)
            OP_LW:   begin dec_o.src = REG_MASK_RS; dec_o.dst = REG_MASK_RT; end
            OP_SW:   dec_o.src = REG_MASK_RS | REG_MASK_RT;
            OP_LA:   dec_o.dst = REG_MASK_RT;
            OP_SA:   dec_o.src = REG_MASK_RT;
            default: ;
          endcase
        end
        default: begin
          dec_o.cls  = CLS_BR;
          dec_o.need = NEED_S0;
        end
      endcase
    end
  end

endmodule

// File: rtl/dual_issue_scheduler.sv
// dual_issue_scheduler
//   Registered dual-issue hazard/steer stage between IF/ID and the two issue
//   pipes (slot 0 = branch pipe, slot 1 = memory pipe). Resolves load-use,
//   intra-pair RAW/WAW and pipe-conflict hazards; a conflicting younger
//   instruction is parked in a one-entry replay buffer and issued later.
//   Ports: clk/reset (sync, active-high), flush, fetch_* group in with
//   fetch_ready handshake, issue_ready back-pressure, issue_* registered out.
//   Optional: DUAL_ISSUE_SCHED_STATS_EN adds stat_load_stall, stat_split,
//   stat_dual saturating counters.
module dual_issue_scheduler
  import dual_issue_scheduler_pkg::*;
#(
  parameter int INST_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int ID_WIDTH     = 8,
  parameter int NUM_REGS     = 32,
  parameter int LOAD_LATENCY = 1,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  fetch_valid,
  output logic                  fetch_ready,
  input  logic [INST_WIDTH-1:0] fetch_inst0,
  input  logic [INST_WIDTH-1:0] fetch_inst1,
  input  logic [ADDR_WIDTH-1:0] fetch_pc0,
  input  logic [ADDR_WIDTH-1:0] fetch_pc1,
  input  logic [ID_WIDTH-1:0]   fetch_id0,
  input  logic [ID_WIDTH-1:0]   fetch_id1,
  input  logic                  issue_ready,
  output logic                  issue_valid0,
  output logic                  issue_valid1,
  output logic [INST_WIDTH-1:0] issue_inst0,
  output logic [INST_WIDTH-1:0] issue_inst1,
  output logic [ADDR_WIDTH-1:0] issue_pc0,
  output logic [ADDR_WIDTH-1:0] issue_pc1,
  output logic [ID_WIDTH-1:0]   issue_id0,
  output logic [ID_WIDTH-1:0]   issue_id1
`ifdef DUAL_ISSUE_SCHED_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  stat_load_stall,
  output logic [CNT_WIDTH-1:0]  stat_split,
  output logic [CNT_WIDTH-1:0]  stat_dual
`endif
);

  localparam logic [BUSY_W-1:0] LAT = BUSY_W'(LOAD_LATENCY);

  state_e                         state_q, state_d;
  logic [1:0]                     vld_q, vld_d;
  logic [1:0][INST_WIDTH-1:0]     inst_q, inst_d;
  logic [1:0][ADDR_WIDTH-1:0]     pc_q, pc_d;
  logic [1:0][ID_WIDTH-1:0]       id_q, id_d;
  logic [INST_WIDTH-1:0]          rep_inst_q, rep_inst_d;
  logic [ADDR_WIDTH-1:0]          rep_pc_q, rep_pc_d;
  logic [ID_WIDTH-1:0]            rep_id_q, rep_id_d;
  logic [NUM_REGS-1:0][BUSY_W-1:0] busy_q, busy_d;

  // Candidates: 0 = older, 1 = younger, 2 = replay entry.
  logic [2:0][INST_WIDTH-1:0] cand;
  dec_t [2:0]                 dec;
  logic [2:0]                 blk;
  logic                       adv, raw, waw, slot_clash, split;
  logic                       sl0, slr;

  assign cand = {rep_inst_q, fetch_inst1, fetch_inst0};

  for (genvar g = 0; g < 3; g++) begin : g_cls
    inst_classifier #(.INST_WIDTH(INST_WIDTH)) u_cls (
      .inst_i (cand[g]),
      .dec_o  (dec[g])
    );
  end

  function automatic logic ld_blk(dec_t d);
    return (((d.src & REG_MASK_RS) != 3'b0) && busy_q[d.rs] != '0) ||
           (((d.src & REG_MASK_RT) != 3'b0) && busy_q[d.rt] != '0) ||
           (((d.src & REG_MASK_RD) != 3'b0) && busy_q[d.rd] != '0);
  endfunction

  function automatic logic is_lw(dec_t d, logic [INST_WIDTH-1:0] inst);
    return d.cls == CLS_MEM && inst[OP_LSB +: 6] == OP_LW;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_blk
    assign blk[g] = ld_blk(dec[g]);
  end

  assign adv        = issue_ready || (vld_q == 2'b00);
  assign raw        = (dec[0].dst != 3'b0) && reads(dec[1], dst_reg(dec[0]));
  assign waw        = (dec[0].dst != 3'b0) && (dec[1].dst != 3'b0) &&
                      (dst_reg(dec[0]) == dst_reg(dec[1]));
  assign slot_clash = (dec[0].need != NEED_ANY) && (dec[0].need == dec[1].need);
  assign split      = raw || waw || slot_clash || blk[1];

  assign fetch_ready = !reset && !flush && adv && (state_q == S_PAIR) && !blk[0];

  always_comb begin
    state_d    = state_q;
    vld_d      = vld_q;
    inst_d     = inst_q;
    pc_d       = pc_q;
    id_d       = id_q;
    rep_inst_d = rep_inst_q;
    rep_pc_d   = rep_pc_q;
    rep_id_d   = rep_id_q;
    busy_d     = busy_q;
    sl0        = (dec[0].need == NEED_S1);
    slr        = (dec[2].need == NEED_S1);
    if (flush) begin
      // Scoreboard kept: in-flight loads are older than flushed work.
      state_d    = S_PAIR;
      vld_d      = '0;
      inst_d     = '0;
      pc_d       = '0;
      id_d       = '0;
      rep_inst_d = '0;
      rep_pc_d   = '0;
      rep_id_d   = '0;
    end else if (adv) begin
      vld_d  = '0;
      inst_d = '0;
      pc_d   = '0;
      id_d   = '0;
      for (int r = 0; r < NUM_REGS; r++)
        if (busy_q[r] != '0) busy_d[r] = busy_q[r] - BUSY_W'(1);
      if (state_q == S_PAIR) begin
        if (fetch_valid && !blk[0]) begin
          if (!split) begin
            // Older takes slot 1 if it needs it, or if the younger needs slot 0.
            sl0 = (dec[0].need == NEED_S1) ||
                  (dec[0].need == NEED_ANY && dec[1].need == NEED_S0);
            vld_d[~sl0]  = 1'b1;
            inst_d[~sl0] = fetch_inst1;
            pc_d[~sl0]   = fetch_pc1;
            id_d[~sl0]   = fetch_id1;
            if (is_lw(dec[1], fetch_inst1)) busy_d[dst_reg(dec[1])] = LAT;
          end else begin
            state_d    = S_REPLAY;
            rep_inst_d = fetch_inst1;
            rep_pc_d   = fetch_pc1;
            rep_id_d   = fetch_id1;
          end
          vld_d[sl0]  = 1'b1;
          inst_d[sl0] = fetch_inst0;
          pc_d[sl0]   = fetch_pc0;
          id_d[sl0]   = fetch_id0;
          if (is_lw(dec[0], fetch_inst0)) busy_d[dst_reg(dec[0])] = LAT;
        end
      end else if (!blk[2]) begin
        vld_d[slr]  = 1'b1;
        inst_d[slr] = rep_inst_q;
        pc_d[slr]   = rep_pc_q;
        id_d[slr]   = rep_id_q;
        if (is_lw(dec[2], rep_inst_q)) busy_d[dst_reg(dec[2])] = LAT;
        state_d    = S_PAIR;
        rep_inst_d = '0;
        rep_pc_d   = '0;
        rep_id_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_PAIR;
      vld_q      <= '0;
      inst_q     <= '0;
      pc_q       <= '0;
      id_q       <= '0;
      rep_inst_q <= '0;
      rep_pc_q   <= '0;
      rep_id_q   <= '0;
      busy_q     <= '0;
    end else begin
      state_q    <= state_d;
      vld_q      <= vld_d;
      inst_q     <= inst_d;
      pc_q       <= pc_d;
      id_q       <= id_d;
      rep_inst_q <= rep_inst_d;
      rep_pc_q   <= rep_pc_d;
      rep_id_q   <= rep_id_d;
      busy_q     <= busy_d;
    end
  end

  assign issue_valid0 = vld_q[0];
  assign issue_valid1 = vld_q[1];
  assign issue_inst0  = inst_q[0];
  assign issue_inst1  = inst_q[1];
  assign issue_pc0    = pc_q[0];
  assign issue_pc1    = pc_q[1];
  assign issue_id0    = id_q[0];
  assign issue_id1    = id_q[1];

`ifdef DUAL_ISSUE_SCHED_STATS_EN
  logic                 go, ev_stall, ev_split, ev_dual;
  logic [CNT_WIDTH-1:0] st_stall_q, st_split_q, st_dual_q;

  assign go       = adv && !flush;
  assign ev_stall = go && ((state_q == S_PAIR && fetch_valid && blk[0]) ||
                           (state_q == S_REPLAY && blk[2]));
  assign ev_split = go && state_q == S_PAIR && fetch_valid && !blk[0] && split;
  assign ev_dual  = go && state_q == S_PAIR && fetch_valid && !blk[0] && !split;

  // Saturating; flush does not clear them.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_stall_q <= '0;
      st_split_q <= '0;
      st_dual_q  <= '0;
    end else begin
      if (ev_stall && !(&st_stall_q)) st_stall_q <= st_stall_q + 1'b1;
      if (ev_split && !(&st_split_q)) st_split_q <= st_split_q + 1'b1;
      if (ev_dual  && !(&st_dual_q))  st_dual_q  <= st_dual_q + 1'b1;
    end
  end

  assign stat_load_stall = st_stall_q;
  assign stat_split      = st_split_q;
  assign stat_dual       = st_dual_q;
`endif

endmodule

// File: doc/dual_issue_scheduler.md
Name: dual_issue_scheduler

Overview:
- Registered successor to the combinational dual-issue hazard/steer logic.
- Sits between IF/ID and the two issue pipes:
  - slot 0 is the branch pipe.
  - slot 1 is the memory pipe.
- Accepts a two-instruction fetch group (inst0 is older) and resolves three hazard types:
  - load-use hazards, via a parametrised load scoreboard;
  - intra-pair RAW/WAW hazards;
  - pipe conflicts.
- A conflicting younger instruction is parked in a one-entry replay buffer and issued alone on a later cycle, instead of being dropped.

Parameters:
- INST_WIDTH, 32, instruction width; field positions as in defines.vh.
- ADDR_WIDTH, 16, PC width.
- ID_WIDTH, 8, instruction ID width.
- NUM_REGS, 32, architectural registers.
- LOAD_LATENCY, 1, issue cycles a LW destination stays unreadable after the LW issues; range 1..7.
- CNT_WIDTH, 16, statistics counter width (optional feature only).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- flush  in  1  mispredict flush
- fetch_valid  in  1  fetch group valid
- fetch_ready  out  1  group accepted this cycle when high together with fetch_valid
- fetch_inst0, fetch_inst1  in  INST_WIDTH  older / younger instruction
- fetch_pc0, fetch_pc1  in  ADDR_WIDTH
- fetch_id0, fetch_id1  in  ID_WIDTH
- issue_ready  in  1  both pipes can take the output register
- issue_valid0, issue_valid1  out  1
- issue_inst0, issue_inst1  out  INST_WIDTH
- issue_pc0, issue_pc1  out  ADDR_WIDTH
- issue_id0, issue_id1  out  ID_WIDTH

Behaviour:
- Clocking and reset:
  - One clock (clk); reset is synchronous and active-high.
  - Reset clears state to S_PAIR, the replay buffer, all scoreboard counters, every issue_* output and both valids to 0.
  - fetch_ready is 0 during reset.
- Instruction classes (shared decode):
  - NOP: instruction == 0.
  - ALU: 00xxxx or 01xxxx, excluding CMP, TEST, CMPI and TESTI.
  - FLAG: CMP, TEST, CMPI, TESTI.
  - MEM: 10xxxx (LW, SW, LA, SA).
  - BR: 11xxxx, plus JR.
- Source/destination masks:
  - ALU-R: src rs,rt; dst rd.
  - ALU-I: src rs; dst rt.
  - LW: src rs; dst rt.
  - SW: src rs,rt.
  - LA: dst rt.
  - SA: src rt.
  - JR: src rs.
  - NOP and other BR: none.
- Pipe needs:
  - FLAG and BR require slot 0.
  - MEM requires slot 1.
  - ALU and NOP may use either slot.
- Advance condition: the output register loads only when issue_ready=1 or both valids are 0. Otherwise all outputs, state and scoreboard hold.
- Output latency: 1 cycle from acceptance to issue_valid.
- Load-use check:
  - A candidate instruction is blocked if any of its sources has busy_cnt[reg] != 0.
  - A blocked older instruction loads nothing: both valids go to 0 (bubble) and fetch_ready=0.
  - If only the younger is blocked, the pair splits (see below).
- Scoreboard update, on each advance:
  - All nonzero counters decrement.
  - Issuing a LW sets busy_cnt[rt] = LOAD_LATENCY; setting wins over decrementing for the same register.
- Split conditions, with the older instruction issuing alone:
  - younger src == older dst (RAW);
  - equal non-null dst (WAW);
  - both need the same slot;
  - younger is load-blocked.
  - On split, the younger goes to the replay buffer with its pc/id, and the state moves to S_REPLAY.
- Steering for an unsplit pair:
  - Place each instruction in its required slot.
  - For ALU/ALU, the older goes to slot 0.
  - The single issued instruction also goes to its required slot; the other slot's valid is 0 and its inst is 0.
- States:
  - S_PAIR: fetch_ready = advance and no older-load block.
  - S_REPLAY: fetch_ready=0. The buffered instruction issues alone when it is not load-blocked, then the state returns to S_PAIR.
- Flush:
  - Highest priority; takes effect at the next edge.
  - Clears both valids and the replay buffer, forces S_PAIR, and sets fetch_ready=0 in that cycle.
  - The scoreboard is retained, because loads already issued are older than the flushed instructions.
- Reset asserted mid-replay: the buffered instruction is discarded.

Optional Feature:
- Macro: DUAL_ISSUE_SCHED_STATS_EN.
- When defined, adds three outputs, each CNT_WIDTH wide:
  - stat_load_stall: counts bubble cycles;
  - stat_split: counts split events;
  - stat_dual: counts dual-issue cycles.
- These counters saturate at all-ones, clear on reset, and do not clear on flush.
- When the macro is undefined, the ports and logic are absent.

Decomposition:
- Shared package / defines.vh additions:
  - class encodings (CLS_NOP, CLS_ALU, CLS_FLAG, CLS_MEM, CLS_BR);
  - slot-need encoding (NEED_ANY, NEED_S0, NEED_S1);
  - state encoding;
  - REG_MASK_RS/RT/RD reuse.
- Sub-module: inst_classifier, combinational. It takes an instruction and returns class, need, src mask, dst mask, rs, rt, rd. It is instantiated three times (inst0, inst1, replay entry).

Test Plan:
- LW r3,0(r1) then next group ADD r4,r3,r2 + ADDI r5,r6,1, with LOAD_LATENCY=1 → one bubble cycle (both valids 0), then the ADD group issues dual; stat_load_stall=1.
- ADDI r2,r1,4 (older) + ADD r7,r2,r2 (younger) → ADDI issues alone in slot 0; next cycle ADD issues alone from replay; fetch_ready is 0 for 1 cycle.
- SW (older) + ADD → SW in slot 1, ADD in slot 0, both valid in one cycle; LW + LW → split, with the second LW issuing the following cycle in slot 1.
- CMP + JMP → split, both in slot 0, on consecutive cycles; ids preserved (id0 then id1).
- Replay pending and flush=1 → next cycle valids 0, state S_PAIR, replayed instruction never appears.
- issue_ready=0 for 3 cycles with a valid pair → outputs stable and fetch_ready=0 throughout; a LW busy counter does not decrement during the hold.
